poly_oscillator_bank: RTL and testbench

//  Parametrised, time-multiplexed N-voice oscillator bank: successor to the fixed 8-voice square Synthesizer.
//  Per voice: phase accumulator, selectable waveform (square/saw/triangle/noise), gate, volume.

---
 rtl/synth_pkg.sv | 33 +++
 rtl/osc_wave_shaper.sv | 53 +++++
 rtl/poly_oscillator_bank.sv | 229 ++++++++++++++++++++++
 tb/tb_poly_oscillator_bank.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types, constants and helpers for the polyphonic oscillator bank.
package synth_pkg;

    // Per-voice waveform selector as presented on the waveforms port.
    typedef enum logic [1:0] {
        WAVE_SQUARE   = 2'd0,
        WAVE_SAW      = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_NOISE    = 2'd3
    } wave_t;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    // Noise generator power-up value.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Volume is Q1.20, so a product is rescaled by this many bits.
    localparam int unsigned VOL_UNITY_SHIFT = 32'd20;

    // One step of the 16-bit Fibonacci LFSR with taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic fb;
        fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
        return {cur[14:0], fb};
    endfunction

endpackage

// File: rtl/osc_wave_shaper.sv
// Combinational waveform generator: maps the top phase bits (or the LFSR)
// to a signed sample of amplitude A = 2^(SAMPLE_W-2).
module osc_wave_shaper
    import synth_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic [SAMPLE_W-2:0]        phase_top,
    input  wave_t                      waveform,
    input  logic [SAMPLE_W-2:0]        noise_bits,
    output logic signed [SAMPLE_W-1:0] wave
);

    localparam logic signed [SAMPLE_W-1:0] AMP    = $signed({2'b01, {(SAMPLE_W-2){1'b0}}});
    localparam logic signed [SAMPLE_W-1:0] AMP_M1 = $signed({2'b00, {(SAMPLE_W-2){1'b1}}});

    logic [SAMPLE_W-3:0]        fold_s;
    logic signed [SAMPLE_W-1:0] fold_x2_s;

    assign fold_s    = phase_top[SAMPLE_W-3:0];
    assign fold_x2_s = $signed({1'b0, fold_s, 1'b0});

    // Select the shape; the triangle ramps up in the first half-cycle and down in the second.
    always_comb begin
        wave = '0;
        case (waveform)
            WAVE_SQUARE: begin
                if (phase_top[SAMPLE_W-2]) begin
                    wave = -AMP;
                end else begin
                    wave = AMP;
                end
            end
            WAVE_SAW: begin
                wave = $signed({1'b0, phase_top}) - AMP;
            end
            WAVE_TRIANGLE: begin
                if (phase_top[SAMPLE_W-2]) begin
                    wave = AMP_M1 - fold_x2_s;
                end else begin
                    wave = fold_x2_s - AMP;
                end
            end
            WAVE_NOISE: begin
                wave = $signed({1'b0, noise_bits}) - AMP;
            end
            default: begin
                wave = '0;
            end
        endcase
    end

endmodule

// File: rtl/poly_oscillator_bank.sv
// Time-multiplexed N-voice oscillator bank. Each sample_req starts a frame
// that walks every voice once (one per clock), mixes the volume-scaled
// waveforms and emits one saturated sample with a one-cycle out_valid.
module poly_oscillator_bank
    import synth_pkg::*;
#(
    parameter int NUM_VOICES  = 8,
    parameter int SAMPLE_W    = 16,
    parameter int FREQ_W      = 20,
    parameter int VOL_W       = 21,
    parameter int PHASE_W     = 32,
    parameter int SAMPLE_RATE = 48000,
    parameter int INC_FRAC    = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  sample_req,
    input  logic [NUM_VOICES-1:0]                 gates,
    input  logic [NUM_VOICES-1:0][1:0]            waveforms,
    input  logic [NUM_VOICES-1:0][FREQ_W-1:0]     frequencies,
    input  logic [NUM_VOICES-1:0][VOL_W-1:0]      voice_volumes,
    output logic                                  busy,
    output logic signed [SAMPLE_W-1:0]            out,
    output logic                                  out_valid
);

    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 2;
    localparam int PROD_W = SAMPLE_W + VOL_W + 1;

    // Phase increment per Hz (Q.5 frequency), with INC_FRAC extra fraction bits, rounded.
    localparam logic [63:0] INC_SCALE =
        ((64'd1 << (PHASE_W - 5 + INC_FRAC)) + 64'(SAMPLE_RATE / 2)) / 64'(SAMPLE_RATE);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    localparam logic signed [ACC_W-1:0] ACC_MAX =
        $signed({{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] ACC_MIN =
        $signed({{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}});
    localparam logic signed [SAMPLE_W-1:0] OUT_MAX = $signed({1'b0, {(SAMPLE_W-1){1'b1}}});
    localparam logic signed [SAMPLE_W-1:0] OUT_MIN = $signed({1'b1, {(SAMPLE_W-1){1'b0}}});

    // Sequencer
    fsm_state_t       state_r;
    fsm_state_t       state_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_s;
    logic             flush_r;
    logic             flush_s;

    // Voice state and pipeline
    logic [PHASE_W-1:0]         phase_r [NUM_VOICES];
    logic [15:0]                lfsr_r;
    logic signed [SAMPLE_W-1:0] wave_r;
    logic [VOL_W-1:0]           vol_r;
    logic                       s1_valid_r;
    logic signed [ACC_W-1:0]    acc_r;

    // Output registers
    logic signed [SAMPLE_W-1:0] out_r;
    logic                       out_valid_r;
    logic                       busy_r;

    // Combinational datapath
    logic [PHASE_W-1:0]         cur_phase_s;
    logic [PHASE_W-1:0]         inc_s;
    logic signed [SAMPLE_W-1:0] shaped_s;
    logic signed [PROD_W-1:0]   wave_ext_s;
    logic signed [PROD_W-1:0]   vol_ext_s;
    logic signed [PROD_W-1:0]   prod_s;
    logic signed [ACC_W-1:0]    contrib_s;
    logic signed [SAMPLE_W-1:0] sat_s;
    logic                       frame_start_s;

    assign busy      = busy_r;
    assign out       = out_r;
    assign out_valid = out_valid_r;

    assign frame_start_s = (state_r == ST_IDLE) && sample_req;

    // Voice currently addressed by the sequencer; shared increment multiplier.
    assign cur_phase_s = phase_r[idx_r];
    assign inc_s       = PHASE_W'((64'(frequencies[idx_r]) * INC_SCALE) >> INC_FRAC);

    osc_wave_shaper #(
        .SAMPLE_W (SAMPLE_W)
    ) u_shaper (
        .phase_top  (cur_phase_s[PHASE_W-1 -: SAMPLE_W-1]),
        .waveform   (wave_t'(waveforms[idx_r])),
        .noise_bits (lfsr_r[SAMPLE_W-2:0]),
        .wave       (shaped_s)
    );

    // Shared volume multiplier: signed wave times unsigned Q1.20 volume, rescaled to sample units.
    assign wave_ext_s = $signed({{(PROD_W-SAMPLE_W){wave_r[SAMPLE_W-1]}}, wave_r});
    assign vol_ext_s  = $signed({{(PROD_W-VOL_W){1'b0}}, vol_r});
    assign prod_s     = wave_ext_s * vol_ext_s;
    assign contrib_s  = ACC_W'(prod_s >>> VOL_UNITY_SHIFT);

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            flush_r <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            flush_r <= flush_s;
        end
    end

    // Sequencer next-state: one voice per RUN cycle, two drain cycles, then DONE.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        flush_s = flush_r;
        case (state_r)
            ST_IDLE: begin
                if (sample_req) begin
                    state_s = ST_RUN;
                    idx_s   = '0;
                    flush_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_FLUSH;
                    flush_s = 1'b0;
                end else begin
                    idx_s = idx_r + IDX_W'(1);
                end
            end
            ST_FLUSH: begin
                if (flush_r) begin
                    state_s = ST_DONE;
                end else begin
                    flush_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Stage 1: shape the addressed voice from its pre-increment phase, then advance or clear that phase.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_r[i] <= '0;
            end
            wave_r     <= '0;
            vol_r      <= '0;
            s1_valid_r <= 1'b0;
        end else if (state_r == ST_RUN) begin
            if (gates[idx_r]) begin
                phase_r[idx_r] <= cur_phase_s + inc_s;
            end else begin
                phase_r[idx_r] <= '0;
            end
            wave_r     <= shaped_s;
            vol_r      <= voice_volumes[idx_r];
            s1_valid_r <= gates[idx_r];
        end else begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: accumulate gated voice contributions, cleared when a frame is accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_r <= '0;
        end else if (frame_start_s) begin
            acc_r <= '0;
        end else if (s1_valid_r) begin
            acc_r <= acc_r + contrib_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Clamp the mix to the signed output range.
    always_comb begin
        sat_s = '0;
        if (acc_r > ACC_MAX) begin
            sat_s = OUT_MAX;
        end else if (acc_r < ACC_MIN) begin
            sat_s = OUT_MIN;
        end else begin
            sat_s = acc_r[SAMPLE_W-1:0];
        end
    end

    // Noise source advances once per completed frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_r <= LFSR_SEED;
        end else if (state_r == ST_DONE) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Registered outputs: busy follows the next state, out/out_valid load on entry to DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_r       <= '0;
        end else begin
            busy_r      <= (state_s != ST_IDLE);
            out_valid_r <= (state_s == ST_DONE);
            if (state_s == ST_DONE) begin
                out_r <= sat_s;
            end else begin
                out_r <= out_r;
            end
        end
    end

endmodule

// File: tb/tb_poly_oscillator_bank.sv
// Directed self-checking bench for poly_oscillator_bank (8 voices, 16-bit samples, 48 kHz).
module tb_poly_oscillator_bank;

    logic                     clk;
    logic                     reset_n;
    logic                     sample_req;
    logic [7:0]               gates;
    logic [7:0][1:0]          waveforms;
    logic [7:0][19:0]         frequencies;
    logic [7:0][20:0]         voice_volumes;
    logic                     busy;
    logic signed [15:0]       out_w;
    logic                     out_valid;

    int n_checks;
    int n_fail;
    int smp;
    int lat;
    int pulses;
    int first_c;

    localparam int UNITY = 32'd1 << 20;
    localparam int HALF  = 32'd1 << 19;

    poly_oscillator_bank #(
        .NUM_VOICES  (8),
        .SAMPLE_W    (16),
        .FREQ_W      (20),
        .VOL_W       (21),
        .PHASE_W     (32),
        .SAMPLE_RATE (48000),
        .INC_FRAC    (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_req    (sample_req),
        .gates         (gates),
        .waveforms     (waveforms),
        .frequencies   (frequencies),
        .voice_volumes (voice_volumes),
        .busy          (busy),
        .out           (out_w),
        .out_valid     (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_voice(input int v, input logic g, input logic [1:0] w,
                             input int hz, input int vol);
        gates[v]         = g;
        waveforms[v]     = w;
        frequencies[v]   = 20'(hz << 5);
        voice_volumes[v] = 21'(vol);
    endtask

    task automatic clear_voices();
        gates         = '0;
        waveforms     = '0;
        frequencies   = '0;
        voice_volumes = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One frame: pulse sample_req, wait (bounded) for out_valid, return sample and latency.
    task automatic run_frame(output int s, output int l);
        @(posedge clk);
        #1 sample_req = 1'b1;
        @(posedge clk);
        #1 sample_req = 1'b0;
        l = 1;
        while (!out_valid && l < 40) begin
            @(posedge clk);
            #1;
            l++;
        end
        s = int'(out_w);
    endtask

    task automatic frame_check(input string tag, input int exp);
        run_frame(smp, lat);
        check({tag, "_lat"}, lat, 11);
        check(tag, smp, exp);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        sample_req = 1'b0;
        reset_n    = 1'b0;
        clear_voices();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", int'(out_w), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        reset_n = 1'b1;

        // Single square voice at fs/4
        set_voice(0, 1'b1, 2'd0, 12000, UNITY);
        frame_check("sq_f0", 16384);
        frame_check("sq_f1", 16384);
        frame_check("sq_f2", -16384);
        frame_check("sq_f3", -16384);
        frame_check("sq_f4", 16384);

        // Latency and dropped request while busy
        @(posedge clk);
        #1 sample_req = 1'b1;
        pulses  = 0;
        first_c = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            sample_req = (c == 3);
            if (c == 3) check("hs_busy", int'(busy), 1);
            if (out_valid) begin
                pulses++;
                if (first_c == 0) first_c = c;
            end
        end
        sample_req = 1'b0;
        check("hs_pulses", pulses, 1);
        check("hs_first", first_c, 11);

        // Mix of two half-volume squares (gate-off frame first zeroes the phases)
        clear_voices();
        frame_check("mix_zero", 0);
        set_voice(0, 1'b1, 2'd0, 12000, HALF);
        set_voice(1, 1'b1, 2'd0, 24000, HALF);
        frame_check("mix_f0", 16384);
        frame_check("mix_f1", 0);
        frame_check("mix_f2", 0);
        frame_check("mix_f3", -16384);

        // Saturation with four unity squares
        clear_voices();
        frame_check("sat_zero", 0);
        for (int v = 0; v < 4; v++) set_voice(v, 1'b1, 2'd0, 12000, UNITY);
        frame_check("sat_f0", 32767);
        frame_check("sat_f1", 32767);
        frame_check("sat_f2", -32768);
        frame_check("sat_f3", -32768);

        // Gate behaviour
        clear_voices();
        frame_check("gate_zero", 0);
        set_voice(0, 1'b1, 2'd0, 12000, UNITY);
        frame_check("gate_f0", 16384);
        gates[0] = 1'b0;
        frame_check("gate_off", 0);
        gates[0] = 1'b1;
        frame_check("gate_on0", 16384);
        frame_check("gate_on1", 16384);

        // Reset mid-frame: no out_valid, phase restarts at 0 (would otherwise give -16384)
        @(posedge clk);
        #1 sample_req = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            sample_req = 1'b0;
            reset_n    = !(c == 4);
            if (out_valid) pulses++;
        end
        reset_n = 1'b1;
        check("abort_pulses", pulses, 0);
        check("abort_busy", int'(busy), 0);
        frame_check("abort_next", 16384);

        // Saw
        do_reset();
        clear_voices();
        set_voice(0, 1'b1, 2'd1, 12000, UNITY);
        frame_check("saw_f0", -16384);
        frame_check("saw_f1", -8192);
        frame_check("saw_f2", 0);
        frame_check("saw_f3", 8192);

        // Triangle
        do_reset();
        set_voice(0, 1'b1, 2'd2, 12000, UNITY);
        frame_check("tri_f0", -16384);
        frame_check("tri_f1", 0);
        frame_check("tri_f2", 16383);
        frame_check("tri_f3", -1);

        // Noise: seed 0xACE1 then 0x59C3
        do_reset();
        set_voice(0, 1'b1, 2'd3, 0, UNITY);
        frame_check("noise_f0", -4895);
        frame_check("noise_f1", 6595);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
